// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer (IDLE -> REQ -> WAIT -> LOAD).
// Issues program-memory reads at the PC and hands fetched words to the
// instruction register with a one-cycle write strobe.
// Branch requests redirect the PC and abandon any fetch that is in flight.
// Optional feature: define FETCH_TIMEOUT_EN to retry a fetch after TIMEOUT
// consecutive WAIT cycles without an acknowledge. The retry is reported on
// fetch_err_o. Without the macro, fetch_err_o is tied low and WAIT lasts until
// an ack or a branch.
// Every output comes from a register. The LOAD actions (ir_we_o, pc_out_o and
// the PC increment) take effect at the edge that leaves LOAD. A branch seen
// during LOAD can therefore still cancel the write strobe.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        branch_en_i,
  input  logic [15:0] branch_target_i,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] ir_d_o,
  output logic        ir_we_o,
  output logic [15:0] pc_out_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] ir_d_q;
  logic [15:0] pc_out_q;
  logic        mem_rd_q;
  logic        ir_we_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q;
  logic            fetch_err_q;
`endif

  // Fetch FSM: state, PC, and all registered outputs in one process.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_d_q      <= 16'h0000;
      pc_out_q    <= 16'h0000;
      mem_rd_q    <= 1'b0;
      ir_we_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      ir_we_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (branch_en_i) begin
            pc_q <= branch_target_i;
          end
          if (!stall_i) begin
            state_q  <= REQ;
            mem_rd_q <= 1'b1;
          end
        end
        REQ, WAIT: begin
          if (branch_en_i) begin
            pc_q     <= branch_target_i;
            state_q  <= REQ;
            mem_rd_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end else if (mem_ack_i) begin
            ir_d_q   <= mem_rdata_i;
            state_q  <= LOAD;
            mem_rd_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end else if (state_q == REQ) begin
            state_q <= WAIT;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            fetch_err_q <= 1'b1;
            state_q     <= REQ;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        LOAD: begin
          if (branch_en_i) begin
            pc_q     <= branch_target_i;
            state_q  <= REQ;
            mem_rd_q <= 1'b1;
          end else begin
            ir_we_q  <= 1'b1;
            pc_out_q <= pc_q;
            pc_q     <= pc_q + 16'd1;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = pc_q;
  assign ir_d_o     = ir_d_q;
  assign ir_we_o    = ir_we_q;
  assign pc_out_o   = pc_out_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err_o = fetch_err_q;
`else
  assign fetch_err_o = 1'b0;
`endif

endmodule
